// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with valid-qualified input,
// selectable overlap mode and a saturating match counter.
//
// Ports:
//   clk_c       clock, rising edge
//   reset_r     asynchronous reset, active-low
//   cfg_load_i  load pattern_i / len_i / overlap_i this cycle
//   pattern_i   pattern, bit [len-1] received first, bit [0] last
//   len_i       pattern length (clamped to MAX_LEN)
//   overlap_i   1 = overlapping detection, 0 = non-overlapping
//   in_valid_i  in_i carries a stream bit this cycle
//   in_i        serial data bit
//   clr_cnt_i   synchronous clear of count_o (wins over a hit)
//   q_o         registered match pulse
//   count_o     saturating match count
//   armed_o     a non-zero length pattern is loaded
module seq_detector_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_c,
  input  logic               reset_r,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  input  logic               in_valid_i,
  input  logic               in_i,
  input  logic               clr_cnt_i,
  output logic               q_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               armed_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] cfg_pattern_q, cfg_pattern_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_overlap_q, cfg_overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               q_q, q_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               armed_q, armed_d;

  logic               accept;
  logic [MAX_LEN-1:0] shift_hist;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  // State register
  always_ff @(posedge clk_c or negedge reset_r) begin
    if (!reset_r) begin
      cfg_pattern_q <= '0;
      cfg_len_q     <= '0;
      cfg_overlap_q <= 1'b0;
      hist_q        <= '0;
      fill_q        <= '0;
      q_q           <= 1'b0;
      count_q       <= '0;
      armed_q       <= 1'b0;
    end else begin
      cfg_pattern_q <= cfg_pattern_d;
      cfg_len_q     <= cfg_len_d;
      cfg_overlap_q <= cfg_overlap_d;
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      q_q           <= q_d;
      count_q       <= count_d;
      armed_q       <= armed_d;
    end
  end

  // Match evaluation on the would-be next history.
  always_comb begin
    len_mask   = '0;
    accept     = in_valid_i & ~cfg_load_i & (cfg_len_q != '0);
    shift_hist = {hist_q[MAX_LEN-2:0], in_i};
    fill_inc   = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < cfg_len_q);
    end
    // Pattern bits at or above cfg_len are masked off as don't-care.
    hit = accept && (fill_inc >= cfg_len_q) &&
          (((shift_hist ^ cfg_pattern_q) & len_mask) == '0);
  end

  // Next-state logic
  always_comb begin
    len_clamped   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    cfg_pattern_d = cfg_pattern_q;
    cfg_len_d     = cfg_len_q;
    cfg_overlap_d = cfg_overlap_q;
    hist_d        = hist_q;
    fill_d        = fill_q;
    count_d       = count_q;
    if (cfg_load_i) begin
      cfg_pattern_d = pattern_i;
      cfg_len_d     = len_clamped;
      cfg_overlap_d = overlap_i;
      hist_d        = '0;
      fill_d        = '0;
    end else if (accept) begin
      // Non-overlapping mode restarts from empty after a match.
      if (hit && !cfg_overlap_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = shift_hist;
        fill_d = fill_inc;
      end
    end
    if (clr_cnt_i) begin
      count_d = '0;
    end else if (hit && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
    q_d     = hit;
    armed_d = (cfg_len_d != '0);
  end

  // Outputs
  always_comb begin
    q_o     = q_q;
    count_o = count_q;
    armed_o = armed_q;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-pattern detector, next generation of the fixed "1011" Mealy detector.
- Pattern value and length (1..MAX_LEN bits) load through a config port. Overlapping or non-overlapping detection is selectable at runtime.
- A valid-qualified input stream replaces the free-running input. The block keeps a saturating match counter.
- Sits on the serial receive path as a framing and sync-word detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk_c  input  1  clock, rising edge.
- reset_r  input  1  reset, asynchronous assert, active-low (0 = reset).
- cfg_load_i  input  1  load pattern_i, len_i and overlap_i this cycle.
- pattern_i  input  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- len_i  input  $clog2(MAX_LEN+1)  pattern length.
- overlap_i  input  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid_i  input  1  in_i is a stream bit this cycle.
- in_i  input  1  serial data bit.
- clr_cnt_i  input  1  synchronous clear of count_o.
- q_o  output  1  registered match pulse.
- count_o  output  CNT_W  saturating number of matches.
- armed_o  output  1  a valid pattern is loaded (cfg_len != 0).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - Outputs: q_o=0, count_o=0, armed_o=0.
  - Internal: cfg_pattern=0, cfg_len=0, cfg_overlap=0, hist=0, fill=0.
- Config load (cfg_load_i=1):
  - Registers pattern_i, len_i and overlap_i.
  - len_i > MAX_LEN is clamped to MAX_LEN.
  - Clears hist and fill.
  - Any in_valid_i bit in the same cycle is discarded; no match is possible that cycle.
  - count_o is preserved.
- Internal state:
  - hist is a MAX_LEN-bit shift register; each accepted bit shifts in at the LSB.
  - fill counts accepted bits since the last clear and saturates at MAX_LEN.
- Accepted bit (in_valid_i=1, cfg_load_i=0, cfg_len!=0):
  - next_hist = {hist[MAX_LEN-2:0], in_i}.
  - next_fill = min(fill+1, MAX_LEN).
  - hit = (next_fill >= cfg_len) and (next_hist[cfg_len-1:0] == cfg_pattern[cfg_len-1:0]).
  - The combinational hit is the Mealy term.
- Match action:
  - hit=1 and cfg_overlap=1: hist and fill update normally.
  - hit=1 and cfg_overlap=0: hist and fill are cleared instead of updated; the next match needs cfg_len fresh bits.
- in_valid_i=0: hist and fill hold; hit=0.
- cfg_len=0: never hits; bits are ignored.
- q_o:
  - q_o <= hit, so it is asserted exactly one cycle after the clock edge that accepted the completing bit. Matches Moore-equivalent latency.
  - One-cycle pulse per match; back-to-back matches give consecutive high cycles.
- count_o:
  - Increments by 1 on each hit and saturates at 2^CNT_W-1.
  - clr_cnt_i has priority: count_o <= 0 even if hit is 1 that cycle.
- armed_o = (cfg_len != 0), registered with the config.
- Reset mid-stream clears everything including the config. No match pulse is produced until a new config load.
- Widths: len compare uses a variable mask, pattern bits above cfg_len are don't-care, and there is no arithmetic overflow on fill.

Test Plan:
- Reset defaults: reset_r=0 mid-stream, release -> q_o=0, count_o=0, armed_o=0; then stream 1011 with no config -> q_o stays 0.
- Overlap: load pattern=8'h0B, len=4, overlap=1; stream 1,0,1,1,0,1,1 (all valid) -> q_o high one cycle after bits 4 and 7; count_o=2.
- Non-overlap: same config with overlap=0, same stream -> q_o high only after bit 4; count_o=1.
- Valid gaps plus reload:
  - in_valid_i low for 3 cycles between bits of 1011 -> single match, latency still one cycle after the last valid bit.
  - cfg_load_i asserted mid-pattern -> history cleared, no match from the partial bits.
- Length edges:
  - len=1, pattern=1, overlap=1, stream 1,1,1 -> q_o high 3 consecutive cycles.
  - len=MAX_LEN, pattern=8'hA5 -> exactly one match after 8 bits.
  - len_i=12 with MAX_LEN=8 -> behaves as len=8.
- Counter: CNT_W=2, drive 5 matches -> count_o saturates at 3; clr_cnt_i on the same cycle as a hit -> count_o=0.
